// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment receiver: active-low hex segment codes,
// FSM state type and the default settle period.
package sevenseg_pkg;

    localparam int SETTLE_CYCLES_DEFAULT = 16;

    // Segment order is {A,B,C,D,E,F,G}; a 0 lights the segment
    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;

    typedef enum logic {
        SETTLE,
        HOLD
    } state_t;

endpackage

// File: rtl/sevenseg_rx_seg_decode.sv
// Combinational seven-segment to hex decoder; hit is low for any pattern
// that is not one of the sixteen hex glyphs.
module seg_decode
    import sevenseg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       hit
);

    always_comb begin
        nibble = 4'h0;
        hit    = 1'b1;
        case (seg)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/sevenseg_rx.sv
// Recovers the eight hex digits shown on a multiplexed seven-segment display.
// Define SEVENSEG_RX_DP_EN to also capture the per-digit decimal points.
module sevenseg_rx
    import sevenseg_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  an,
    input  logic [6:0]  seg,
    input  logic        dp,
    output logic [31:0] digits,
    output logic [7:0]  valid,
    output logic        frame_done,
    output logic        err,
    output logic [2:0]  err_digit,
    output logic [7:0]  dp_flags
);

`ifdef SEVENSEG_RX_DP_EN
    localparam int SW = 16;
    logic [SW-1:0] raw;
    logic          s_dp;
    assign raw = {an, seg, dp};
`else
    localparam int SW = 15;
    logic [SW-1:0] raw;
    logic          unused_dp;
    assign raw       = {an, seg};
    assign unused_dp = dp;
`endif

    localparam logic [15:0] LAST = 16'(SETTLE_CYCLES - 1);

    logic [SW-1:0] sync1, sync2, prev;
    logic [7:0]    s_an;
    logic [6:0]    s_seg;
    logic [7:0]    sel;
    logic [2:0]    idx;
    logic          single;
    logic [3:0]    nibble;
    logic          hit;
    logic          changed;
    logic          capture;
    logic [15:0]   count;
    logic [7:0]    seen;
    state_t        state;

    assign s_an    = sync2[SW-1 -: 8];
    assign s_seg   = sync2[SW-9 -: 7];
`ifdef SEVENSEG_RX_DP_EN
    assign s_dp    = sync2[0];
`endif
    assign changed = (sync2 != prev);
    assign capture = (state == SETTLE) && !changed && (count == LAST);
    assign single  = ($countones(sel) == 1);

    seg_decode u_decode (
        .seg    (s_seg),
        .nibble (nibble),
        .hit    (hit)
    );

    always_comb begin
        sel = ~s_an;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (sel[i]) idx = 3'(i);
        end
    end

    // Reset to all-ones so the synchronizer looks like a blanked display
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
            prev  <= '1;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= SETTLE;
            count      <= '0;
            seen       <= '0;
            digits     <= '0;
            valid      <= '0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            err_digit  <= 3'd0;
`ifdef SEVENSEG_RX_DP_EN
            dp_flags   <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            err        <= 1'b0;
            case (state)
                SETTLE: begin
                    if (changed) begin
                        count <= '0;
                    end else if (count == LAST) begin
                        state <= HOLD;
                        count <= '0;
                    end else begin
                        count <= count + 16'd1;
                    end
                end
                HOLD: begin
                    if (changed) begin
                        state <= SETTLE;
                        count <= '0;
                    end
                end
                default: begin
                    state <= SETTLE;
                    count <= '0;
                end
            endcase

            // Blanked scans (no anode low) fall through without touching anything
            if (capture) begin
                if (single) begin
                    if (hit) begin
                        digits[4*idx +: 4] <= nibble;
                        valid[idx]         <= 1'b1;
`ifdef SEVENSEG_RX_DP_EN
                        dp_flags[idx]      <= ~s_dp;
`endif
                    end else begin
                        valid[idx] <= 1'b0;
                        err        <= 1'b1;
                        err_digit  <= idx;
                    end
                    if ((seen | sel) == 8'hFF) begin
                        frame_done <= 1'b1;
                        seen       <= '0;
                    end else begin
                        seen <= seen | sel;
                    end
                end else if (sel != 8'h00) begin
                    err       <= 1'b1;
                    err_digit <= 3'd0;
                end
            end
        end
    end

`ifndef SEVENSEG_RX_DP_EN
    assign dp_flags = '0;
`endif

endmodule

// File: doc/sevenseg_rx.md
SEVENSEG_RX -- requirements
Module: sevenseg_rx

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16; cycles the sampled {an,seg} must stay unchanged before capture (legal range 2..65535).
REQ-002 SHALL have port clk, input, 1, system clock (100 MHz).
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port an, input, 8, digit anodes, active-low, an[0] = rightmost digit.
REQ-005 SHALL have port seg, input, 7, segments {A,B,C,D,E,F,G}, active-low.
REQ-006 SHALL have port dp, input, 1, decimal point, active-low.
REQ-007 SHALL have port digits, output, 32, recovered nibbles d7..d0, d0 in [3:0].
REQ-008 SHALL have port valid, output, 8, per-digit flag meaning the last capture for that digit decoded successfully.
REQ-009 SHALL have port frame_done, output, 1, one-cycle pulse when all 8 digits have been captured since the previous pulse.
REQ-010 SHALL have port err, output, 1, one-cycle pulse on an illegal capture.
REQ-011 SHALL have port err_digit, output, 3, index of the last illegal capture (0 on a multi-anode error).
REQ-012 SHALL have port dp_flags, output, 8, per-digit captured decimal point, active-high.

Function
REQ-013 SHALL pass an, seg and dp through a 2-flop synchronizer before any other use.
REQ-014 SHALL run a 2-state FSM:
- SETTLE: counts cycles in which the synced {an,seg,dp} equals its previous-cycle value; any change resets the count to 0.
- When the count reaches SETTLE_CYCLES-1, SHALL perform exactly one capture and move to HOLD.
- HOLD: no captures; any input change moves to SETTLE with the count at 0.
REQ-015 Capture with exactly one an bit low (index i):
- If seg matches one of the 16 hex codes (0-9, A, b, C, d, E, F; e.g. 0 = 0000001, 8 = 0000000, F = 0111000), SHALL write digits[4i+3:4i] and set valid[i].
- Otherwise SHALL clear valid[i], leave digits[4i+3:4i] unchanged, pulse err and set err_digit = i.
REQ-016 Capture with an = 8'hFF (blanking) SHALL be ignored: no write, no error, no mask update.
REQ-017 Capture with two or more an bits low SHALL pulse err, set err_digit = 0, and write nothing.
REQ-018 SHALL keep an 8-bit seen mask, setting bit i on every single-anode capture, legal or illegal.
REQ-019 When a capture completes seen = 8'hFF, SHALL pulse frame_done in the same cycle the digits/valid update becomes visible, and clear seen.
REQ-020 Latency from a stable input change to the digits update SHALL be 2 + SETTLE_CYCLES + 1 clk cycles.
REQ-021 Re-capturing an already-seen digit before the frame completes SHALL overwrite its data without affecting frame_done timing.

Reset
REQ-022 On rst high, asynchronously: digits = 0, valid = 0, dp_flags = 0, seen = 0, frame_done = 0, err = 0, err_digit = 0, count = 0, FSM = SETTLE, synchronizer flops = all-ones (blank).
REQ-023 Reset asserted mid-settle or mid-frame SHALL discard the partial state; capture SHALL resume only after a full SETTLE_CYCLES period following reset release.

Configuration
REQ-024 With macro SEVENSEG_RX_DP_EN defined, a legal capture SHALL store the inverted dp into dp_flags[i].
REQ-025 Without SEVENSEG_RX_DP_EN, dp SHALL be unsampled (no synchronizer) and dp_flags SHALL be constant 0.

Structure
REQ-026 Package sevenseg_pkg SHALL hold the 16 active-low segment code constants, the FSM state enum and the SETTLE_CYCLES default.
REQ-027 Sub-module seg_decode SHALL be combinational: 7-bit seg in, 4-bit nibble out, 1-bit hit out; instantiated once.

Verification
REQ-028 Bench SHALL cover, with SETTLE_CYCLES = 16:
- Multiplexed scan of 32'h89ABCDEF, 16384 cycles per digit -> digits = 32'h89ABCDEF, valid = 8'hFF, one frame_done per 8-digit scan.
- an = 8'b11111011, seg = 7'b1111110 (illegal) -> err pulse, err_digit = 2, valid[2] = 0, digits[11:8] unchanged.
- an = 8'b11110011 held 40 cycles -> one err pulse, err_digit = 0, no digits change, no repeat pulse while held.
- seg toggling every 10 cycles on digit 0 -> no capture; then stable for 19 cycles -> capture lands on exactly cycle 19.
- rst pulsed after 5 digits of a frame -> all outputs 0; next full scan yields exactly one frame_done.
- With SEVENSEG_RX_DP_EN, dp low on digit 7 only -> dp_flags = 8'h80; without the macro -> dp_flags = 8'h00.
